mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 64, meaning the maximum cycles one grant may be held while the other requester waits before hold_err is raised.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port icache_req  input  1  I-cache fill requests the memory port; held high for the whole fill.
REQ-005 SHALL have port icache_addr  input  16  I-cache word address.
REQ-006 SHALL have port dcache_req  input  1  D-cache fill/write requests the memory port; held high for the whole transaction.
REQ-007 SHALL have port dcache_addr  input  16  D-cache word address.
REQ-008 SHALL have port dcache_wr  input  1  D-cache access is a write; qualified by dcache_req.
REQ-009 SHALL have port dcache_wdata  input  16  D-cache write data.
REQ-010 SHALL have port mem_data_valid  input  1  memory read data valid this cycle.
REQ-011 SHALL have port mem_rdata  input  16  memory read data.
REQ-012 SHALL have port icache_grant, dcache_grant  output  1 each  registered grant to each requester.
REQ-013 SHALL have port icache_data_valid, dcache_data_valid  output  1 each  mem_data_valid routed to the granted requester.
REQ-014 SHALL have port rdata  output  16  mem_rdata pass-through to both caches.
REQ-015 SHALL have port mem_enable, mem_wr  output  1 each  memory access enable and write strobe.
REQ-016 SHALL have port mem_addr, mem_wdata  output  16 each  memory address and write data.
REQ-017 SHALL have port arb_busy  output  1  high whenever either grant is high.
REQ-018 SHALL have port hold_err  output  1  sticky starvation flag.

Function
REQ-019 SHALL implement states IDLE, GRANT_I, GRANT_D; icache_grant = (state==GRANT_I), dcache_grant = (state==GRANT_D), both registered.
REQ-020 IDLE: only icache_req -> GRANT_I; only dcache_req -> GRANT_D; both -> the requester NOT recorded in last_served; neither -> stay IDLE.
REQ-021 GRANT_X with req_X high SHALL stay GRANT_X (no preemption, ever).
REQ-022 GRANT_X with req_X low SHALL go to GRANT_Y if req_Y high, else IDLE, in the same edge; no idle bubble.
REQ-023 last_served SHALL update to X on every entry into GRANT_X.
REQ-024 Grant latency: request seen at edge N with port free -> grant high after edge N+1's register update (one cycle).
REQ-025 mem_enable = grant_X & req_X; mem_wr = dcache_grant & dcache_req & dcache_wr; icache never writes.
REQ-026 mem_addr/mem_wdata SHALL mux from the granted requester; in IDLE, or when granted to I-cache (wdata), drive 16'h0000.
REQ-027 X_data_valid = mem_data_valid & grant_X; mem_data_valid in IDLE SHALL be dropped; rdata = mem_rdata always.
REQ-028 hold counter: clears on every state change; increments each cycle in GRANT_X while req_Y high; saturates at MAX_HOLD.
REQ-029 hold_err SHALL set when counter == MAX_HOLD and remain high until reset.
REQ-030 Requester dropping and re-raising req in the same grant is illegal; arbiter treats the drop as release.

Reset
REQ-031 rst_n low at an edge SHALL force state IDLE, last_served = I (D wins first tie), counter 0, hold_err 0, regardless of transaction in progress.
REQ-032 After reset all outputs SHALL be 0 (grants, valids, mem_enable, mem_wr, mem_addr, mem_wdata, arb_busy, hold_err); rdata follows mem_rdata.
REQ-033 Reset mid-grant SHALL abandon the transaction; no data_valid routed until a new grant.

Verification
REQ-034 After reset, assert icache_req and dcache_req same cycle -> dcache_grant=1 next cycle, icache_grant=0; drop dcache_req -> icache_grant=1 next cycle, no IDLE cycle.
REQ-035 D-cache write: dcache_req=1, dcache_wr=1, addr 16'h1230, wdata 16'hBEEF -> once granted mem_enable=1, mem_wr=1, mem_addr=16'h1230, mem_wdata=16'hBEEF.
REQ-036 Only I-cache fill granted, pulse mem_data_valid 8 times with rdata 16'h0001..16'h0008 -> icache_data_valid pulses 8 times, dcache_data_valid stays 0.
REQ-037 Hold I grant 64 cycles with dcache_req high (MAX_HOLD=64) -> hold_err=1 on counter reaching 64, no preemption, stays 1 after grants change.
REQ-038 Assert rst_n=0 mid D-cache fill -> next edge all grants 0, hold_err 0; then tie -> D granted first again.
REQ-039 mem_data_valid pulsed in IDLE -> both data_valid outputs remain 0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_if
// Brief    : I-cache / D-cache / memory port bundle for the memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================

interface mem_arbiter_if;
    logic        icache_req;
    logic [15:0] icache_addr;
    logic        dcache_req;
    logic [15:0] dcache_addr;
    logic        dcache_wr;
    logic [15:0] dcache_wdata;
    logic        mem_data_valid;
    logic [15:0] mem_rdata;

    logic        icache_grant;
    logic        dcache_grant;
    logic        icache_data_valid;
    logic        dcache_data_valid;
    logic [15:0] rdata;
    logic        mem_enable;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        arb_busy;
    logic        hold_err;

    // Arbiter side: takes requests and memory returns, drives grants and the memory port.
    modport slave (
        input  icache_req, icache_addr, dcache_req, dcache_addr, dcache_wr,
               dcache_wdata, mem_data_valid, mem_rdata,
        output icache_grant, dcache_grant, icache_data_valid, dcache_data_valid,
               rdata, mem_enable, mem_wr, mem_addr, mem_wdata, arb_busy, hold_err
    );

    modport master (
        output icache_req, icache_addr, dcache_req, dcache_addr, dcache_wr,
               dcache_wdata, mem_data_valid, mem_rdata,
        input  icache_grant, dcache_grant, icache_data_valid, dcache_data_valid,
               rdata, mem_enable, mem_wr, mem_addr, mem_wdata, arb_busy, hold_err
    );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Two-requester (I-cache / D-cache) memory port arbiter with
//            non-preemptive grants, alternating tie-break and starvation flag.
// Revision : 1.0 - initial release
// ============================================================================

module mem_arbiter #(
    parameter int MAX_HOLD = 64
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    mem_arbiter_if.slave bus
);

    localparam int                 c_CNT_W    = $clog2(MAX_HOLD + 1);
    localparam logic [c_CNT_W-1:0] c_MAX_HOLD = c_CNT_W'(MAX_HOLD);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_last_d;      // last_served: 0 = I-cache, 1 = D-cache
    logic [c_CNT_W-1:0] r_hold_cnt;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic               r_hold_err;
    logic               w_other_waiting;
    logic               w_grant_i;
    logic               w_grant_d;

    assign w_grant_i = (r_state == GRANT_I);
    assign w_grant_d = (r_state == GRANT_D);

    // The owner keeps the port while it requests; on release the other side
    // takes over on the same edge, so there is never an idle bubble.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.icache_req && bus.dcache_req)
                    w_state_next = r_last_d ? GRANT_I : GRANT_D;
                else if (bus.icache_req)
                    w_state_next = GRANT_I;
                else if (bus.dcache_req)
                    w_state_next = GRANT_D;
            end
            GRANT_I: begin
                if (!bus.icache_req)
                    w_state_next = bus.dcache_req ? GRANT_D : IDLE;
            end
            GRANT_D: begin
                if (!bus.dcache_req)
                    w_state_next = bus.icache_req ? GRANT_I : IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_other_waiting = (w_grant_i && bus.dcache_req) ||
                             (w_grant_d && bus.icache_req);

    always_comb begin
        w_cnt_next = r_hold_cnt;
        if (w_state_next != r_state)
            w_cnt_next = '0;
        else if (w_other_waiting && (r_hold_cnt != c_MAX_HOLD))
            w_cnt_next = r_hold_cnt + c_CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_last_d   <= 1'b0;
            r_hold_cnt <= '0;
            r_hold_err <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_hold_cnt <= w_cnt_next;
            if (w_state_next != r_state) begin
                if (w_state_next == GRANT_I)
                    r_last_d <= 1'b0;
                else if (w_state_next == GRANT_D)
                    r_last_d <= 1'b1;
            end
            if (w_cnt_next == c_MAX_HOLD)
                r_hold_err <= 1'b1;
        end
    end

    assign bus.icache_grant      = w_grant_i;
    assign bus.dcache_grant      = w_grant_d;
    assign bus.arb_busy          = w_grant_i | w_grant_d;
    assign bus.hold_err          = r_hold_err;

    // Read returns outside a grant are dropped.
    assign bus.icache_data_valid = bus.mem_data_valid & w_grant_i;
    assign bus.dcache_data_valid = bus.mem_data_valid & w_grant_d;
    assign bus.rdata             = bus.mem_rdata;

    assign bus.mem_enable = (w_grant_i & bus.icache_req) | (w_grant_d & bus.dcache_req);
    assign bus.mem_wr     = w_grant_d & bus.dcache_req & bus.dcache_wr;
    assign bus.mem_addr   = w_grant_i ? bus.icache_addr :
                            w_grant_d ? bus.dcache_addr : 16'h0000;
    assign bus.mem_wdata  = w_grant_d ? bus.dcache_wdata : 16'h0000;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Self-checking bench for mem_arbiter: vector table, directed
//            corner sequences and randomized traffic against a port-owner model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_mem_arbiter;

    localparam int MAX_HOLD = 64;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    int   ipulse   = 0;
    int   dpulse   = 0;

    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Reference: who owns the port (0 none, 1 I-cache, 2 D-cache), who was
    // served last, how long the other side has been waiting, sticky error.
    int m_owner;
    int m_last;
    int m_wait;
    bit m_err;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        bit ir, dr;
        int nxt;
        ir = bus.icache_req;
        dr = bus.dcache_req;
        if (!rst_n) begin
            m_owner = 0; m_last = 1; m_wait = 0; m_err = 0;
            return;
        end
        if ((m_owner == 1 && ir) || (m_owner == 2 && dr)) nxt = m_owner;
        else if (ir && dr)                                 nxt = 3 - m_last;
        else if (ir)                                       nxt = 1;
        else if (dr)                                       nxt = 2;
        else                                               nxt = 0;
        if (nxt != m_owner) begin
            m_wait = 0;
            if (nxt != 0) m_last = nxt;
        end else if ((m_owner == 1 && dr) || (m_owner == 2 && ir)) begin
            m_wait = (m_wait < MAX_HOLD) ? m_wait + 1 : MAX_HOLD;
        end
        m_owner = nxt;
        if (m_wait == MAX_HOLD) m_err = 1;
    endtask

    task automatic model_check();
        logic [15:0] e_addr;
        logic [15:0] e_wdata;
        e_addr  = (m_owner == 1) ? bus.icache_addr : (m_owner == 2) ? bus.dcache_addr : 16'h0000;
        e_wdata = (m_owner == 2) ? bus.dcache_wdata : 16'h0000;
        chk("m icache_grant", 16'(bus.icache_grant), 16'(m_owner == 1));
        chk("m dcache_grant", 16'(bus.dcache_grant), 16'(m_owner == 2));
        chk("m icache_data_valid", 16'(bus.icache_data_valid), 16'(bus.mem_data_valid && m_owner == 1));
        chk("m dcache_data_valid", 16'(bus.dcache_data_valid), 16'(bus.mem_data_valid && m_owner == 2));
        chk("m mem_enable", 16'(bus.mem_enable),
            16'((m_owner == 1 && bus.icache_req) || (m_owner == 2 && bus.dcache_req)));
        chk("m mem_wr", 16'(bus.mem_wr), 16'(m_owner == 2 && bus.dcache_req && bus.dcache_wr));
        chk("m mem_addr", bus.mem_addr, e_addr);
        chk("m mem_wdata", bus.mem_wdata, e_wdata);
        chk("m rdata", bus.rdata, bus.mem_rdata);
        chk("m arb_busy", 16'(bus.arb_busy), 16'(m_owner != 0));
        chk("m hold_err", 16'(bus.hold_err), 16'(m_err));
    endtask

    // Inputs are held across the cycle; outputs checked at the falling edge.
    task automatic cycle();
        @(negedge clk);
        model_check();
        @(posedge clk);
        model_step();
        #1;
    endtask

    always @(negedge clk) begin
        if (bus.icache_data_valid === 1'b1) ipulse++;
        if (bus.dcache_data_valid === 1'b1) dpulse++;
    end

    typedef struct {
        logic        rst_n, ireq, dreq, dwr, mval;
        logic [15:0] iaddr, daddr, wdata, mrdata;
        logic        e_ig, e_dg, e_iv, e_dv, e_en, e_wr, e_busy, e_err;
        logic [15:0] e_addr, e_wdata;
    } vec_t;

    vec_t vec [12];

    initial begin
        // field order: rst_n ireq dreq dwr mval | iaddr daddr wdata mrdata |
        //              ig dg iv dv en wr busy err | addr wdata
        vec[0]  = '{0,0,0,0,1, 16'h0100,16'h1230,16'hBEEF,16'hA5A5, 0,0,0,0,0,0,0,0, 16'h0000,16'h0000};
        vec[1]  = '{1,1,1,1,0, 16'h0100,16'h1230,16'hBEEF,16'h0000, 0,0,0,0,0,0,0,0, 16'h0000,16'h0000};
        vec[2]  = '{1,1,1,1,0, 16'h0100,16'h1230,16'hBEEF,16'h0000, 0,1,0,0,1,1,1,0, 16'h1230,16'hBEEF};
        vec[3]  = '{1,1,0,1,1, 16'h0100,16'h1230,16'hBEEF,16'h1111, 0,1,0,1,0,0,1,0, 16'h1230,16'hBEEF};
        vec[4]  = '{1,1,0,0,1, 16'h0100,16'h1230,16'hBEEF,16'h0001, 1,0,1,0,1,0,1,0, 16'h0100,16'h0000};
        vec[5]  = '{1,0,0,0,0, 16'h0100,16'h1230,16'hBEEF,16'h0000, 1,0,0,0,0,0,1,0, 16'h0100,16'h0000};
        vec[6]  = '{1,0,0,0,1, 16'h0100,16'h1230,16'hBEEF,16'h2222, 0,0,0,0,0,0,0,0, 16'h0000,16'h0000};
        vec[7]  = '{1,1,1,0,0, 16'h0100,16'h1230,16'hBEEF,16'h0000, 0,0,0,0,0,0,0,0, 16'h0000,16'h0000};
        vec[8]  = '{1,1,1,0,1, 16'h0100,16'h1230,16'hBEEF,16'h3333, 0,1,0,1,1,0,1,0, 16'h1230,16'hBEEF};
        vec[9]  = '{0,1,1,0,0, 16'h0100,16'h1230,16'hBEEF,16'h0000, 0,1,0,0,1,0,1,0, 16'h1230,16'hBEEF};
        vec[10] = '{1,1,1,0,1, 16'h0100,16'h1230,16'hBEEF,16'h4444, 0,0,0,0,0,0,0,0, 16'h0000,16'h0000};
        vec[11] = '{1,1,1,1,1, 16'h0100,16'h1230,16'hBEEF,16'h5555, 0,1,0,1,1,1,1,0, 16'h1230,16'hBEEF};

        rst_n = 1'b0;
        bus.icache_req = 1'b0; bus.icache_addr = 16'h0; bus.dcache_req = 1'b0;
        bus.dcache_addr = 16'h0; bus.dcache_wr = 1'b0; bus.dcache_wdata = 16'h0;
        bus.mem_data_valid = 1'b0; bus.mem_rdata = 16'h0;
        @(posedge clk);
        model_step();
        #1;

        for (int i = 0; i < 12; i++) begin
            rst_n              = vec[i].rst_n;
            bus.icache_req     = vec[i].ireq;
            bus.dcache_req     = vec[i].dreq;
            bus.dcache_wr      = vec[i].dwr;
            bus.mem_data_valid = vec[i].mval;
            bus.icache_addr    = vec[i].iaddr;
            bus.dcache_addr    = vec[i].daddr;
            bus.dcache_wdata   = vec[i].wdata;
            bus.mem_rdata      = vec[i].mrdata;
            @(negedge clk);
            chk($sformatf("v%0d icache_grant", i), 16'(bus.icache_grant), 16'(vec[i].e_ig));
            chk($sformatf("v%0d dcache_grant", i), 16'(bus.dcache_grant), 16'(vec[i].e_dg));
            chk($sformatf("v%0d icache_data_valid", i), 16'(bus.icache_data_valid), 16'(vec[i].e_iv));
            chk($sformatf("v%0d dcache_data_valid", i), 16'(bus.dcache_data_valid), 16'(vec[i].e_dv));
            chk($sformatf("v%0d mem_enable", i), 16'(bus.mem_enable), 16'(vec[i].e_en));
            chk($sformatf("v%0d mem_wr", i), 16'(bus.mem_wr), 16'(vec[i].e_wr));
            chk($sformatf("v%0d arb_busy", i), 16'(bus.arb_busy), 16'(vec[i].e_busy));
            chk($sformatf("v%0d hold_err", i), 16'(bus.hold_err), 16'(vec[i].e_err));
            chk($sformatf("v%0d mem_addr", i), bus.mem_addr, vec[i].e_addr);
            chk($sformatf("v%0d mem_wdata", i), bus.mem_wdata, vec[i].e_wdata);
            chk($sformatf("v%0d rdata", i), bus.rdata, vec[i].mrdata);
            @(posedge clk);
            model_step();
            #1;
        end

        // I-cache fill: eight data beats, all routed to the I-cache only.
        rst_n = 1'b0; bus.icache_req = 1'b0; bus.dcache_req = 1'b0; bus.mem_data_valid = 1'b0;
        cycle();
        rst_n = 1'b1; bus.icache_req = 1'b1;
        cycle();
        ipulse = 0; dpulse = 0;
        for (int k = 1; k <= 8; k++) begin
            bus.mem_data_valid = 1'b1; bus.mem_rdata = 16'(k);
            cycle();
            bus.mem_data_valid = 1'b0;
            cycle();
        end
        chk("fill icache_data_valid pulses", 16'(ipulse), 16'd8);
        chk("fill dcache_data_valid pulses", 16'(dpulse), 16'd0);

        // Starvation: I-cache keeps the port while the D-cache waits MAX_HOLD cycles.
        rst_n = 1'b0; bus.icache_req = 1'b0;
        cycle();
        rst_n = 1'b1; bus.icache_req = 1'b1;
        cycle();
        bus.dcache_req = 1'b1;
        repeat (MAX_HOLD - 1) cycle();
        chk("hold_err before limit", 16'(bus.hold_err), 16'd0);
        cycle();
        chk("hold_err at limit", 16'(bus.hold_err), 16'd1);
        chk("no preemption at limit", 16'(bus.icache_grant), 16'd1);
        bus.icache_req = 1'b0;
        cycle();
        chk("handover to dcache", 16'(bus.dcache_grant), 16'd1);
        chk("hold_err sticky after handover", 16'(bus.hold_err), 16'd1);
        bus.dcache_req = 1'b0;
        cycle();
        chk("idle after release", 16'(bus.arb_busy), 16'd0);
        chk("hold_err sticky in idle", 16'(bus.hold_err), 16'd1);

        // Reset in the middle of a D-cache fill, then a tie goes to D again.
        bus.dcache_req = 1'b1;
        cycle();
        rst_n = 1'b0;
        cycle();
        chk("reset mid-fill dcache_grant", 16'(bus.dcache_grant), 16'd0);
        chk("reset mid-fill hold_err", 16'(bus.hold_err), 16'd0);
        rst_n = 1'b1; bus.icache_req = 1'b1;
        cycle();
        chk("tie after reset dcache_grant", 16'(bus.dcache_grant), 16'd1);
        chk("tie after reset icache_grant", 16'(bus.icache_grant), 16'd0);

        // Randomized traffic against the owner model.
        for (int n = 0; n < 600; n++) begin
            rst_n = ($urandom_range(0, 79) != 0);
            if ($urandom_range(0, 4) == 0) bus.icache_req = ~bus.icache_req;
            if ($urandom_range(0, 4) == 0) bus.dcache_req = ~bus.dcache_req;
            bus.dcache_wr      = 1'($urandom_range(0, 1));
            bus.icache_addr    = 16'($urandom);
            bus.dcache_addr    = 16'($urandom);
            bus.dcache_wdata   = 16'($urandom);
            bus.mem_data_valid = 1'($urandom_range(0, 1));
            bus.mem_rdata      = 16'($urandom);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
